// File: rtl/handshaking_master_if.sv
// Purpose: valid/ready byte channel between handshaking_master and handshaking_slave.
// Signals:
//   data   master -> slave  payload
//   valid  master -> slave  payload valid
//   ready  slave  -> master slave accepts payload at this edge
interface handshaking_master_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/handshaking_master.sv
// Purpose: buffers producer bytes in a small FIFO and presents them one at a
//   time on a valid/ready channel; counts completed handshakes.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   wr_en_i       producer write strobe
//   wr_data_i     producer data
//   full_o        FIFO holds DEPTH entries
//   empty_o       FIFO holds no entries (output register excluded)
//   xfer_count_o  completed handshakes, wraps
//   ch            channel master side (data/valid out, ready in)
module handshaking_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_WIDTH-1:0]  xfer_count_o,
  handshaking_master_if.master  ch
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      occ_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  xfer_count_q;
  logic                  push_c, pop_c, xfer_c;

  // Flags decode straight from the occupancy register.
  assign full_o       = (occ_q == OCC_W'(DEPTH));
  assign empty_o      = (occ_q == OCC_W'(0));
  assign push_c       = wr_en_i & ~full_o;
  assign xfer_c       = valid_q & ch.ready;
  assign ch.data      = data_q;
  assign ch.valid     = valid_q;
  assign xfer_count_o = xfer_count_q;

  // Next-state and pop decision; only pops from registered entries, so a write
  // can never bypass into data_out in the cycle it arrives.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    pop_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_o) begin
          pop_c   = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ch.ready) begin
          if (!empty_o) begin
            pop_c  = 1'b1;
            data_d = mem_q[rd_ptr_q];
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, output register, pointers, occupancy and transfer counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      data_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
      if (xfer_c) xfer_count_q <= xfer_count_q + CNT_WIDTH'(1);
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
